// File: rtl/sha256_pkg.sv
// sha256_pkg: constants and FSM encoding shared by the SHA-256 front end.
package sha256_pkg;

  localparam int         BLOCK_W     = 512;
  localparam int         BLOCK_BYTES = BLOCK_W / 8;
  localparam int         LEN_OFF     = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    ISSUE = 2'd2,
    WAIT  = 2'd3
  } pad_state_e;

endpackage

// File: rtl/sha256_pad_insert.sv
// sha256_pad_insert: combinational pad-marker insertion and length append.
module sha256_pad_insert
  import sha256_pkg::*;
(
  input  logic [BLOCK_W-1:0] buf_i,
  input  logic [6:0]         p_i,
  input  logic [63:0]        bitcnt_i,
  input  logic               len_en_i,
  output logic [BLOCK_W-1:0] blk_o
);

  // Keep bytes before p, place the marker at p, zero the rest, then overlay
  // the big-endian bit count. A p of 64 passes the buffer through untouched.
  always_comb begin
    blk_o = '0;
    for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
      if (i < {25'd0, p_i}) begin
        blk_o[BLOCK_W-1-8*i -: 8] = buf_i[BLOCK_W-1-8*i -: 8];
      end else if (i == {25'd0, p_i}) begin
        blk_o[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
      end
    end
    if (len_en_i) begin
      blk_o[BLOCK_W-8*LEN_OFF-1:0] = bitcnt_i;
    end
  end

endmodule

// File: rtl/sha256_padder.sv
// sha256_padder: packs a 32-bit word stream into padded 512-bit SHA-256 blocks.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [2:0]         in_bytes,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] M_out,
  output logic               blk_valid,
  output logic               blk_first,
  output logic               blk_last,
  input  logic               core_done
);

  pad_state_e         state_q, state_d;
  logic               rdy_q;
  logic [3:0]         wptr_q, wptr_d;
  logic [63:0]        bitcnt_q, bitcnt_d;
  logic [BLOCK_W-1:0] buf_q, buf_d;
  logic [BLOCK_W-1:0] mout_q, mout_d;
  logic [BLOCK_W-1:0] pad_blk;
  logic [6:0]         p_q, p_d;
  logic               final_q, final_d;
  logic               lenonly_q, lenonly_d;
  logic               pend_q, pend_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               accept;
  logic               len_en;
  logic [2:0]         nbytes;

  assign in_ready  = rdy_q && (state_q == FILL);
  assign accept    = in_valid && in_ready;
  assign nbytes    = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
  assign len_en    = final_q && (lenonly_q || (p_q < 7'(LEN_OFF)));
  assign M_out     = mout_q;
  assign blk_valid = (state_q == ISSUE);
  assign blk_first = first_q;
  assign blk_last  = last_q;

  sha256_pad_insert u_pad_insert (
    .buf_i    (buf_q),
    .p_i      (p_q),
    .bitcnt_i (bitcnt_q),
    .len_en_i (len_en),
    .blk_o    (pad_blk)
  );

  // Next-state logic for the fill / pad / issue / wait sequence.
  // A full non-final block also passes through PAD (p=64, no length) so that
  // every word-completed block sees the same two-cycle latency.
  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    bitcnt_d  = bitcnt_q;
    buf_d     = buf_q;
    mout_d    = mout_q;
    p_d       = p_q;
    final_d   = final_q;
    lenonly_d = lenonly_q;
    pend_d    = pend_q;
    first_d   = first_q;
    last_d    = last_q;
    case (state_q)
      FILL: begin
        if (accept) begin
          buf_d[{4'd15 - wptr_q, 5'd0} +: 32] = in_data;
          wptr_d = wptr_q + 4'd1;
          if (in_last) begin
            bitcnt_d  = bitcnt_q + {58'd0, nbytes, 3'd0};
            p_d       = {1'b0, wptr_q, 2'b00} + {4'd0, nbytes};
            final_d   = 1'b1;
            lenonly_d = 1'b0;
            state_d   = PAD;
          end else begin
            bitcnt_d = bitcnt_q + 64'd32;
            if (wptr_q == 4'd15) begin
              p_d       = 7'd64;
              final_d   = 1'b0;
              lenonly_d = 1'b0;
              state_d   = PAD;
            end
          end
        end
      end
      PAD: begin
        mout_d  = pad_blk;
        last_d  = len_en;
        pend_d  = final_q && !len_en;
        if (final_q && !len_en) begin
          // Marker already placed (p in 56..63): follow with a length-only
          // block; message filled the block (p=64): follow with marker+length.
          lenonly_d = (p_q != 7'd64);
          p_d       = (p_q == 7'd64) ? 7'd0 : 7'd64;
        end
        state_d = ISSUE;
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          buf_d   = '0;
          first_d = last_q;
          if (pend_q) begin
            pend_d  = 1'b0;
            state_d = PAD;
          end else begin
            wptr_d    = '0;
            final_d   = 1'b0;
            lenonly_d = 1'b0;
            p_d       = '0;
            if (last_q) begin
              bitcnt_d = '0;
            end
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      rdy_q     <= 1'b0;
      wptr_q    <= '0;
      bitcnt_q  <= '0;
      buf_q     <= '0;
      mout_q    <= '0;
      p_q       <= '0;
      final_q   <= 1'b0;
      lenonly_q <= 1'b0;
      pend_q    <= 1'b0;
      first_q   <= 1'b1;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rdy_q     <= 1'b1;
      wptr_q    <= wptr_d;
      bitcnt_q  <= bitcnt_d;
      buf_q     <= buf_d;
      mout_q    <= mout_d;
      p_q       <= p_d;
      final_q   <= final_d;
      lenonly_q <= lenonly_d;
      pend_q    <= pend_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: random message streams checked against a byte-level padding model.
module tb_sha256_padder;

  localparam int CLK_P   = 10;
  localparam int LAT_CYC = 2;  // handshake cycle is cycle 0

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         in_ready;
  logic [511:0] M_out;
  logic         blk_valid;
  logic         blk_first;
  logic         blk_last;
  logic         core_done = 1'b0;

  int           n_checks = 0;
  int           n_fail = 0;
  int           n_blocks = 0;
  logic [511:0] exp_blk[$];
  bit           exp_first[$];
  bit           exp_last[$];
  time          t_evt = 0;
  bit           evt_is_word = 1'b0;
  logic [511:0] last_blk = '0;

  always #(CLK_P/2) clk = ~clk;

  sha256_padder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .in_ready  (in_ready),
    .M_out     (M_out),
    .blk_valid (blk_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .core_done (core_done)
  );

  // Reference: message, 0x80, zeros up to 56 mod 64, 64-bit big-endian bit length.
  task automatic build_expected(input logic [7:0] msg[$]);
    logic [7:0]   pm[$];
    logic [63:0]  len;
    logic [511:0] blk;
    int           nblk;
    pm = msg;
    pm.push_back(8'h80);
    while (pm.size() % 64 != 56) pm.push_back(8'h00);
    len = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) pm.push_back(len[8*i +: 8]);
    nblk = pm.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      blk = '0;
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pm[64*b+i];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit empty_tail, input bit gaps,
                          input int max_words);
    logic [31:0] wd[$];
    bit          wl[$];
    logic [2:0]  wb[$];
    int          n;
    int          nfull;
    int          rem;
    n = msg.size();
    nfull = n / 4;
    rem = n % 4;
    for (int i = 0; i < nfull; i++) begin
      wd.push_back({msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
      wl.push_back(1'b0);
      wb.push_back(3'($urandom_range(0, 7)));
    end
    if (rem != 0) begin
      logic [31:0] w;
      w = $urandom;
      for (int j = 0; j < rem; j++) w[31-8*j -: 8] = msg[4*nfull+j];
      wd.push_back(w);
      wl.push_back(1'b1);
      wb.push_back(3'(rem));
    end else if (n == 0 || empty_tail) begin
      wd.push_back($urandom);
      wl.push_back(1'b1);
      wb.push_back(3'd0);
    end else begin
      wl[wl.size()-1] = 1'b1;
      wb[wb.size()-1] = 3'd4;
    end
    for (int i = 0; i < wd.size(); i++) begin
      int cnt;
      if (i == max_words) break;
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_data  = $urandom;
          in_last  = 1'($urandom);
          in_bytes = 3'($urandom);
          @(negedge clk);
        end
      end
      in_valid = 1'b1;
      in_data  = wd[i];
      in_last  = wl[i];
      in_bytes = wb[i];
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 5000) begin
        @(negedge clk);
        cnt++;
      end
      if (in_ready !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: in_ready=%b required 1 within 5000 cycles", in_ready);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk);
      t_evt = $time;
      evt_is_word = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Stand-in for the hash core: checks each issued block, then answers after a delay.
  task automatic core_model(input int hold);
    while (exp_blk.size() != 0) begin
      logic [511:0] eb;
      logic [511:0] snap;
      bit           ef;
      bit           el;
      int           cnt;
      int           bad;
      int           h;
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (blk_valid !== 1'b1 && cnt < 5000);
      if (blk_valid !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL blk_valid_timeout: blk_valid=%b required 1 within 5000 cycles", blk_valid);
        exp_blk.delete();
        exp_first.delete();
        exp_last.delete();
        break;
      end
      n_blocks++;
      eb = exp_blk.pop_front();
      ef = exp_first.pop_front();
      el = exp_last.pop_front();
      n_checks++;
      if (M_out !== eb) begin
        n_fail++;
        $display("FAIL block_data: got %h required %h", M_out, eb);
      end
      n_checks++;
      if (blk_first !== ef) begin
        n_fail++;
        $display("FAIL blk_first: got %b required %b", blk_first, ef);
      end
      n_checks++;
      if (blk_last !== el) begin
        n_fail++;
        $display("FAIL blk_last: got %b required %b", blk_last, el);
      end
      if (evt_is_word) begin
        n_checks++;
        if ($time - t_evt != time'((LAT_CYC - 1) * CLK_P + CLK_P / 2)) begin
          n_fail++;
          $display("FAIL latency: got %0d time units after accepting edge required %0d",
                   $time - t_evt, (LAT_CYC - 1) * CLK_P + CLK_P / 2);
        end
      end
      last_blk = M_out;
      snap = M_out;
      bad = 0;
      h = (hold > 0) ? hold : int'($urandom_range(1, 6));
      for (int k = 0; k < h; k++) begin
        @(negedge clk);
        if (blk_valid !== 1'b0 || in_ready !== 1'b0 || M_out !== snap ||
            blk_first !== ef || blk_last !== el) bad++;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL hold_stable: %0d unstable cycles while awaiting core_done, required 0", bad);
      end
      core_done = 1'b1;
      @(posedge clk);
      t_evt = $time;
      evt_is_word = 1'b0;
      @(negedge clk);
      core_done = 1'b0;
    end
  endtask

  task automatic run_msg(input logic [7:0] msg[$], input bit empty_tail, input bit gaps,
                         input int hold);
    int extra;
    extra = 0;
    build_expected(msg);
    fork
      send_msg(msg, empty_tail, gaps, -1);
      core_model(hold);
    join
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (blk_valid !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL extra_blk_valid: got %0d extra pulse cycles required 0", extra);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_msg: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_first !== 1'b1 || blk_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready=%b valid=%b first=%b last=%b required 0 0 1 0",
               in_ready, blk_valid, blk_first, blk_last);
    end
    n_checks++;
    if (M_out !== 512'd0) begin
      n_fail++;
      $display("FAIL reset_mout: got %h required 0", M_out);
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_before_edge: in_ready=%b required 0", in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_edge: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic check_abc_block(input string tag);
    logic [511:0] want;
    want = '0;
    want[511:480] = 32'h61626380;
    want[31:0] = 32'h00000018;
    n_checks++;
    if (last_blk !== want) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, last_blk, want);
    end
  endtask

  task automatic test_abc();
    logic [7:0] m[$];
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0, 1'b0, 0);
    check_abc_block("abc_block");
  endtask

  task automatic test_empty();
    logic [7:0]   m[$];
    logic [511:0] want;
    m = {};
    want = '0;
    want[511:480] = 32'h80000000;
    run_msg(m, 1'b0, 1'b0, 0);
    n_checks++;
    if (last_blk !== want) begin
      n_fail++;
      $display("FAIL empty_block: got %h required %h", last_blk, want);
    end
  endtask

  task automatic test_56();
    logic [7:0] m[$];
    int         n0;
    for (int i = 0; i < 56; i++) m.push_back(8'($urandom));
    n0 = n_blocks;
    run_msg(m, 1'b0, 1'b1, 0);
    n_checks++;
    if (n_blocks - n0 != 2 || last_blk[511:64] !== 448'd0 || last_blk[63:0] !== 64'h1C0) begin
      n_fail++;
      $display("FAIL len56_block: got %0d blocks, tail %h required 2 blocks, tail 1c0",
               n_blocks - n0, last_blk[63:0]);
    end
  endtask

  task automatic test_64();
    logic [7:0]   m[$];
    logic [511:0] want;
    int           n0;
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
    want = '0;
    want[511:480] = 32'h80000000;
    want[63:0] = 64'h200;
    n0 = n_blocks;
    run_msg(m, 1'b0, 1'b0, 0);
    n_checks++;
    if (n_blocks - n0 != 2) begin
      n_fail++;
      $display("FAIL len64_pulses: got %0d required 2", n_blocks - n0);
    end
    n_checks++;
    if (last_blk !== want) begin
      n_fail++;
      $display("FAIL len64_block: got %h required %h", last_blk, want);
    end
  endtask

  task automatic test_hold86();
    logic [7:0] m[$];
    for (int i = 0; i < 70; i++) m.push_back(8'($urandom));
    run_msg(m, 1'b0, 1'b1, 86);
  endtask

  task automatic test_spurious_done();
    logic [7:0] m[$];
    int         bad;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      core_done = 1'b1;
      @(negedge clk);
      if (blk_valid !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    core_done = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL spurious_done: %0d disturbed cycles required 0", bad);
    end
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0, 1'b0, 0);
    check_abc_block("abc_after_spurious");
  endtask

  task automatic test_reset_mid();
    logic [7:0] m[$];
    for (int i = 0; i < 80; i++) m.push_back(8'($urandom));
    send_msg(m, 1'b0, 1'b1, 7);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (M_out !== 512'd0 || blk_first !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_state: mout_zero=%b first=%b ready=%b required 1 1 0",
               M_out == 512'd0, blk_first, in_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    m = '{8'h61, 8'h62, 8'h63};
    run_msg(m, 1'b0, 1'b0, 0);
    check_abc_block("abc_after_reset");
  endtask

  task automatic test_boundaries();
    int lens[17] = '{1, 3, 4, 52, 55, 56, 57, 59, 60, 63, 64, 65, 119, 120, 127, 128, 129};
    foreach (lens[j]) begin
      logic [7:0] m[$];
      for (int i = 0; i < lens[j]; i++) m.push_back(8'($urandom));
      run_msg(m, 1'($urandom), 1'b1, 0);
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 6; j++) begin
      logic [7:0] m[$];
      int         n;
      n = $urandom_range(0, 150);
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      run_msg(m, 1'($urandom), 1'b0, 0);
    end
  endtask

  initial begin
    #(CLK_P * 90000);
    $display("FAIL watchdog: time limit reached, required completion before it");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_abc();
    test_empty();
    test_56();
    test_64();
    test_hold86();
    test_spurious_done();
    test_reset_mid();
    test_boundaries();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
